// File: rtl/axis_rx_pkg.sv
// Shared types and constants for the AXI-Stream packet receiver.
package axis_rx_pkg;

    localparam int AXIS_W = 32;

    localparam int ERR_SHORT = 0;
    localparam int ERR_LONG  = 1;
    localparam int ERR_DATA  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/axis_pkt_rx_if.sv
// AXI-Stream beat channel between the PS DMA (master) and the receiver (slave).
interface axis_pkt_rx_if;
    import axis_rx_pkg::*;

    logic [AXIS_W-1:0] tdata;
    logic              tvalid;
    logic              tlast;
    logic              tready;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/axis_word_packer.sv
// Packs accepted 32-bit beats into OUT_WORDS-wide groups; beat 0 of a group lands in the low word.
module axis_word_packer
    import axis_rx_pkg::*;
#(
    parameter int OUT_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        beat,
    input  logic                        restart,
    input  logic [AXIS_W-1:0]           data,
    output logic [AXIS_W*OUT_WORDS-1:0] out_data,
    output logic                        out_valid
);

    localparam int SW = (OUT_WORDS > 1) ? $clog2(OUT_WORDS) : 1;

    logic [SW-1:0]                      slot;
    logic [OUT_WORDS-1:0][AXIS_W-1:0]   shift_q;
    logic [OUT_WORDS-1:0][AXIS_W-1:0]   shift_d;
    logic                               last_slot;

    assign last_slot = (slot == SW'(OUT_WORDS - 1));

    // New beats enter at the top so that after a full group the first beat sits in word 0.
    always_comb begin
        shift_d = shift_q;
        for (int i = 0; i < OUT_WORDS - 1; i++) begin
            shift_d[i] = shift_q[i + 1];
        end
        shift_d[OUT_WORDS-1] = data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot      <= '0;
            shift_q   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (restart) begin
                slot <= '0;
            end else if (beat) begin
                shift_q <= shift_d;
                slot    <= last_slot ? '0 : slot + 1'b1;
                if (last_slot) begin
                    out_data  <= shift_d;
                    out_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axis_pkt_rx.sv
// AXI-Stream packet receiver: length and incrementing-pattern checks, beat packing, statistics.
//   state | meaning
//   IDLE  | not accepting; waits for start
//   RECV  | accepting, checking and packing beats of the current packet
//   DRAIN | packet overran PKT_LEN; discard beats up to tlast
//   DONE  | one cycle; counts the packet and issues pkt_done
module axis_pkt_rx
    import axis_rx_pkg::*;
#(
    parameter int PKT_LEN   = 256,
    parameter int OUT_WORDS = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        clr,
    axis_pkt_rx_if.slave                M_AXIS,
    output logic [AXIS_W*OUT_WORDS-1:0] out_data,
    output logic                        out_valid,
    output logic                        pkt_done,
    output logic [31:0]                 pkt_cnt,
    output logic [31:0]                 err_cnt,
    output logic [2:0]                  err_flags,
    output logic                        busy
);

    state_t             state_q, state_d;
    logic [15:0]        beat_idx;
    logic               pkt_err;
    logic               seeded;
    logic [AXIS_W-1:0]  exp_data;
    logic               tready_q;

    logic               beat_acc, recv_beat, at_end;
    logic               set_short, set_long, set_data;
    logic               inc_good, inc_bad;
    logic [2:0]         new_err;

    assign M_AXIS.tready = tready_q;
    assign beat_acc  = M_AXIS.tvalid && tready_q;
    assign recv_beat = beat_acc && (state_q == RECV);
    assign at_end    = (beat_idx == 16'(PKT_LEN - 1));
    assign busy      = (state_q == RECV) || (state_q == DRAIN);

    assign set_short = recv_beat && M_AXIS.tlast && !at_end;
    assign set_long  = recv_beat && !M_AXIS.tlast && at_end;
    assign set_data  = recv_beat && seeded && (M_AXIS.tdata != exp_data);
    assign inc_good  = (state_q == DONE) && !pkt_err;
    assign inc_bad   = (state_q == DONE) && pkt_err;

    always_comb begin
        new_err            = '0;
        new_err[ERR_SHORT] = set_short;
        new_err[ERR_LONG]  = set_long;
        new_err[ERR_DATA]  = set_data;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RECV;
            RECV:    if (recv_beat && (M_AXIS.tlast || at_end))
                         state_d = M_AXIS.tlast ? DONE : DRAIN;
            DRAIN:   if (beat_acc && M_AXIS.tlast) state_d = DONE;
            DONE:    state_d = start ? RECV : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tready_q  <= 1'b0;
            pkt_done  <= 1'b0;
            beat_idx  <= '0;
            pkt_err   <= 1'b0;
            seeded    <= 1'b0;
            exp_data  <= '0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            err_flags <= '0;
        end else begin
            // tready follows the next state so it is a pure register, never a function of tvalid.
            tready_q <= (state_d == RECV) || (state_d == DRAIN);
            pkt_done <= (state_q == DONE);

            if (state_q == IDLE || state_q == DONE) begin
                beat_idx <= '0;
                pkt_err  <= 1'b0;
            end else if (recv_beat) begin
                beat_idx <= beat_idx + 16'd1;
                if (|new_err) pkt_err <= 1'b1;
            end

            if (clr)            seeded <= 1'b0;
            else if (recv_beat) seeded <= 1'b1;
            if (recv_beat) exp_data <= M_AXIS.tdata + 32'd1;

            err_flags <= (clr ? 3'b000 : err_flags) | new_err;

            if (clr)                                   pkt_cnt <= {31'd0, inc_good};
            else if (inc_good && pkt_cnt != '1)        pkt_cnt <= pkt_cnt + 32'd1;
            if (clr)                                   err_cnt <= {31'd0, inc_bad};
            else if (inc_bad && err_cnt != '1)         err_cnt <= err_cnt + 32'd1;
        end
    end

    axis_word_packer #(.OUT_WORDS(OUT_WORDS)) u_packer (
        .clk       (clk),
        .rst       (rst),
        .beat      (recv_beat),
        .restart   (state_q == IDLE || state_q == DONE),
        .data      (M_AXIS.tdata),
        .out_data  (out_data),
        .out_valid (out_valid)
    );

endmodule

// File: tb/tb_axis_pkt_rx.sv
// Directed + randomized bench for axis_pkt_rx against a packet-level reference model.
module tb_axis_pkt_rx;

    localparam int PKT_LEN   = 256;
    localparam int OUT_WORDS = 8;
    localparam int OW        = 32 * OUT_WORDS;

    logic          clk = 1'b0;
    logic          rst, start, clr;
    logic [OW-1:0] out_data;
    logic          out_valid, pkt_done, busy;
    logic [31:0]   pkt_cnt, err_cnt;
    logic [2:0]    err_flags;

    always #5 clk = ~clk;

    axis_pkt_rx_if bus ();

    axis_pkt_rx #(.PKT_LEN(PKT_LEN), .OUT_WORDS(OUT_WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .clr       (clr),
        .M_AXIS    (bus),
        .out_data  (out_data),
        .out_valid (out_valid),
        .pkt_done  (pkt_done),
        .pkt_cnt   (pkt_cnt),
        .err_cnt   (err_cnt),
        .err_flags (err_flags),
        .busy      (busy)
    );

    int            checks = 0;
    int            errors = 0;
    int            done_cnt = 0;
    int            done_base = 0;
    int            stuck = 0;
    logic [OW-1:0] got_q[$];
    logic [OW-1:0] exp_q[$];
    logic [31:0]   pkt_q[$];
    logic [31:0]   full_q[$];

    // reference model state
    bit            m_seeded = 0;
    logic [31:0]   m_exp = 0;
    logic [31:0]   m_pktc = 0;
    logic [31:0]   m_errc = 0;
    logic [2:0]    m_flags = 0;
    bit            m_bad = 0;

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) got_q.push_back(out_data);
        if (pkt_done === 1'b1) done_cnt++;
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic build_pkt(input int n, input logic [31:0] base);
        pkt_q.delete();
        for (int i = 0; i < n; i++) pkt_q.push_back(base + 32'(i));
    endtask

    // Expected outcome of one packet whose tlast is on its final beat.
    task automatic model_pkt();
        int n, k;
        logic [OW-1:0] v;
        n = pkt_q.size();
        k = (n < PKT_LEN) ? n : PKT_LEN;
        m_bad = 0;
        for (int i = 0; i < k; i++) begin
            if (!m_seeded) m_seeded = 1;
            else if (pkt_q[i] != m_exp) begin
                m_bad = 1;
                m_flags[2] = 1'b1;
            end
            m_exp = pkt_q[i] + 32'd1;
        end
        if (n < PKT_LEN) begin m_bad = 1; m_flags[0] = 1'b1; end
        if (n > PKT_LEN) begin m_bad = 1; m_flags[1] = 1'b1; end
        for (int g = 0; g < k / OUT_WORDS; g++) begin
            for (int j = 0; j < OUT_WORDS; j++) v[j*32 +: 32] = pkt_q[g*OUT_WORDS + j];
            exp_q.push_back(v);
        end
    endtask

    task automatic model_done();
        if (m_bad) m_errc++;
        else       m_pktc++;
    endtask

    task automatic model_clear();
        m_pktc = 0; m_errc = 0; m_flags = 0; m_seeded = 0;
    endtask

    task automatic send_pkt(input bit has_last, input int stop_at, input bit gaps);
        logic r;
        bit   ok;
        done_base = done_cnt;
        stuck = 0;
        for (int i = 0; i < pkt_q.size(); i++) begin
            if (i == stop_at) start = 1'b0;
            if (gaps && $urandom_range(0, 3) == 0) begin
                bus.tvalid = 1'b0;
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            bus.tvalid = 1'b1;
            bus.tdata  = pkt_q[i];
            bus.tlast  = has_last && (i == pkt_q.size() - 1);
            ok = 0;
            for (int t = 0; t < 64; t++) begin
                r = bus.tready;
                @(negedge clk);
                if (r) begin ok = 1; break; end
            end
            if (!ok) begin stuck++; break; end
        end
        bus.tvalid = 1'b0;
        bus.tlast  = 1'b0;
        chk("beat_accept_timeouts", OW'(stuck), OW'(0));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear();
    endtask

    task automatic check_pkt(input string tag);
        int t;
        t = 0;
        while (done_cnt == done_base && t < 20) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_pkt_done"}, OW'(done_cnt - done_base), OW'(1));
        chk({tag, "_pkt_cnt"}, OW'(pkt_cnt), OW'(m_pktc));
        chk({tag, "_err_cnt"}, OW'(err_cnt), OW'(m_errc));
        chk({tag, "_err_flags"}, OW'(err_flags), OW'(m_flags));
        chk({tag, "_groups"}, OW'(got_q.size()), OW'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0)
            chk({tag, "_out_data"}, got_q.pop_front(), exp_q.pop_front());
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_tready"}, OW'(bus.tready), OW'(0));
        chk({tag, "_out_valid"}, OW'(out_valid), OW'(0));
        chk({tag, "_pkt_done"}, OW'(pkt_done), OW'(0));
        chk({tag, "_pkt_cnt"}, OW'(pkt_cnt), OW'(0));
        chk({tag, "_err_cnt"}, OW'(err_cnt), OW'(0));
        chk({tag, "_err_flags"}, OW'(err_flags), OW'(0));
        chk({tag, "_busy"}, OW'(busy), OW'(0));
        chk({tag, "_out_data"}, out_data, OW'(0));
    endtask

    initial begin
        int n, kind, g0, d0, hi;
        rst = 1'b1; start = 1'b0; clr = 1'b0;
        bus.tvalid = 1'b0; bus.tdata = '0; bus.tlast = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        start = 1'b1;

        // basic good packet 0..255
        build_pkt(PKT_LEN, 32'd0);
        model_pkt(); model_done();
        send_pkt(1, -1, 0);
        check_pkt("basic");

        // short packet, then a good one
        do_clr();
        build_pkt(100, m_exp);
        model_pkt(); model_done();
        send_pkt(1, -1, 0);
        check_pkt("short");
        build_pkt(PKT_LEN, m_exp);
        model_pkt(); model_done();
        send_pkt(1, -1, 0);
        check_pkt("after_short");

        // long packet of 300 beats
        do_clr();
        build_pkt(300, m_exp);
        model_pkt(); model_done();
        send_pkt(1, -1, 0);
        check_pkt("long");

        // data mismatch in the second of three chained packets
        do_clr();
        build_pkt(PKT_LEN, 32'd0);
        model_pkt(); model_done(); send_pkt(1, -1, 0); check_pkt("mm_first");
        build_pkt(PKT_LEN, m_exp);
        pkt_q[10] = 32'hDEADBEEF;
        model_pkt(); model_done(); send_pkt(1, -1, 0); check_pkt("mm_second");
        build_pkt(PKT_LEN, m_exp);
        model_pkt(); model_done(); send_pkt(1, -1, 0); check_pkt("mm_third");

        // randomized packets with random gaps, lengths and corruption
        do_clr();
        for (int it = 0; it < 6; it++) begin
            kind = $urandom_range(0, 2);
            n = (kind == 0) ? PKT_LEN :
                (kind == 1) ? $urandom_range(1, PKT_LEN - 1) : PKT_LEN + $urandom_range(1, 40);
            build_pkt(n, (it == 0) ? $urandom : m_exp);
            if ($urandom_range(0, 2) == 0)
                pkt_q[$urandom_range(0, n - 1)] ^= ($urandom | 32'd1);
            model_pkt(); model_done();
            send_pkt(1, -1, 1);
            check_pkt("random");
        end

        // start dropped mid-packet, then tvalid held in IDLE
        build_pkt(PKT_LEN, m_exp);
        model_pkt(); model_done();
        send_pkt(1, 50, 1);
        check_pkt("stop");
        chk("stop_busy", OW'(busy), OW'(0));
        g0 = got_q.size(); d0 = done_cnt; hi = 0;
        bus.tvalid = 1'b1; bus.tdata = m_exp;
        repeat (10) begin
            @(negedge clk);
            if (bus.tready !== 1'b0) hi++;
        end
        chk("idle_tready_high_cycles", OW'(hi), OW'(0));
        chk("idle_no_out_valid", OW'(got_q.size()), OW'(g0));
        chk("idle_no_pkt_done", OW'(done_cnt), OW'(d0));
        bus.tvalid = 1'b0;
        start = 1'b1;

        // clr in the DONE cycle of a good packet
        build_pkt(PKT_LEN, m_exp);
        model_pkt();
        send_pkt(1, -1, 0);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_clear(); model_done();
        check_pkt("clr_done");
        build_pkt(PKT_LEN, $urandom);
        model_pkt(); model_done(); send_pkt(1, -1, 0); check_pkt("reseed");

        // rst at beat 128
        build_pkt(PKT_LEN, m_exp);
        full_q = pkt_q;
        pkt_q.delete();
        for (int i = 0; i < 128; i++) pkt_q.push_back(full_q[i]);
        send_pkt(0, -1, 0);
        rst = 1'b1;
        @(negedge clk);
        chk_all_zero("rst_mid");
        rst = 1'b0;
        model_clear();
        got_q.delete(); exp_q.delete();
        pkt_q.delete();
        for (int i = 128; i < PKT_LEN; i++) pkt_q.push_back(full_q[i]);
        model_pkt(); model_done();
        send_pkt(1, -1, 0);
        check_pkt("after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
